// File: rtl/board_reader.sv
// Snapshots the packed board and move data, then streams the 64 squares over valid/ready.
// Optional BOARD_READER_FLIP_EN reverses the scan order when black is to move.
module board_reader #(
    parameter int unsigned SQUARES = 64,
    parameter int unsigned PIECE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SQUARES*PIECE_W-1:0] board,
    input  logic [13:0]                moveData,
    input  logic                       start,
    input  logic                       rd_ready,
    output logic                       sq_valid,
    output logic [5:0]                 sq_index,
    output logic [PIECE_W-1:0]         sq_piece,
    output logic                       sq_cursor,
    output logic                       sq_target,
    output logic                       busy,
    output logic                       done,
    output logic [6:0]                 occ_count,
    output logic                       kings_ok,
    output logic                       bad_code
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                     state_q, state_d;
    logic [SQUARES*PIECE_W-1:0] snap_q, snap_d;
    logic [12:0]                move_q, move_d;
    logic [5:0]                 idx_q, idx_d;
    logic [PIECE_W-1:0]         piece_q, piece_d;
    logic                       cursor_q, cursor_d, target_q, target_d;
    logic [6:0]                 occ_acc_q, occ_acc_d, occ_q, occ_d;
    logic [1:0]                 wk_q, wk_d, bk_q, bk_d;
    logic                       bad_acc_q, bad_acc_d, kings_q, kings_d, badc_q, badc_d;

    logic                       flip_start, flip_run;
    logic [5:0]                 idx_first, idx_last, idx_next;
    logic [6:0]                 occ_inc;
    logic [1:0]                 wk_inc, bk_inc;
    logic                       bad_inc;

    logic [PIECE_W-1:0] in_sq   [SQUARES];
    logic [PIECE_W-1:0] snap_sq [SQUARES];

    for (genvar i = 0; i < SQUARES; i++) begin : g_sq
        assign in_sq[i]   = board[i*PIECE_W +: PIECE_W];
        assign snap_sq[i] = snap_q[i*PIECE_W +: PIECE_W];
    end

`ifdef BOARD_READER_FLIP_EN
    logic flip_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flip_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            flip_q <= moveData[13];
        end
    end
    assign flip_start = moveData[13];
    assign flip_run   = flip_q;
`else
    assign flip_start = 1'b0;
    assign flip_run   = 1'b0;
`endif

    assign idx_first = flip_start ? 6'd63 : 6'd0;
    assign idx_last  = flip_run ? 6'd0 : 6'd63;
    assign idx_next  = flip_run ? idx_q - 6'd1 : idx_q + 6'd1;

    // Accumulators including the beat currently on the bus; king counts saturate at 2.
    assign occ_inc = occ_acc_q + 7'(piece_q[2:0] != 3'd0);
    assign wk_inc  = (piece_q == PIECE_W'(6) && wk_q != 2'd2) ? wk_q + 2'd1 : wk_q;
    assign bk_inc  = (piece_q == PIECE_W'(14) && bk_q != 2'd2) ? bk_q + 2'd1 : bk_q;
    assign bad_inc = bad_acc_q | (piece_q[2:0] == 3'd7);

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        move_d    = move_q;
        idx_d     = idx_q;
        piece_d   = piece_q;
        cursor_d  = cursor_q;
        target_d  = target_q;
        occ_acc_d = occ_acc_q;
        wk_d      = wk_q;
        bk_d      = bk_q;
        bad_acc_d = bad_acc_q;
        occ_d     = occ_q;
        kings_d   = kings_q;
        badc_d    = badc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d    = board;
                    move_d    = moveData[12:0];
                    idx_d     = idx_first;
                    piece_d   = in_sq[idx_first];
                    cursor_d  = (idx_first == moveData[5:0]);
                    target_d  = moveData[12] && (idx_first == moveData[11:6]);
                    occ_acc_d = 7'd0;
                    wk_d      = 2'd0;
                    bk_d      = 2'd0;
                    bad_acc_d = 1'b0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (rd_ready) begin
                    occ_acc_d = occ_inc;
                    wk_d      = wk_inc;
                    bk_d      = bk_inc;
                    bad_acc_d = bad_inc;
                    if (idx_q == idx_last) begin
                        occ_d   = occ_inc;
                        kings_d = (wk_inc == 2'd1) && (bk_inc == 2'd1);
                        badc_d  = bad_inc;
                        state_d = StDone;
                    end else begin
                        idx_d    = idx_next;
                        piece_d  = snap_sq[idx_next];
                        cursor_d = (idx_next == move_q[5:0]);
                        target_d = move_q[12] && (idx_next == move_q[11:6]);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            move_q    <= '0;
            idx_q     <= '0;
            piece_q   <= '0;
            cursor_q  <= 1'b0;
            target_q  <= 1'b0;
            occ_acc_q <= '0;
            wk_q      <= '0;
            bk_q      <= '0;
            bad_acc_q <= 1'b0;
            occ_q     <= '0;
            kings_q   <= 1'b0;
            badc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            move_q    <= move_d;
            idx_q     <= idx_d;
            piece_q   <= piece_d;
            cursor_q  <= cursor_d;
            target_q  <= target_d;
            occ_acc_q <= occ_acc_d;
            wk_q      <= wk_d;
            bk_q      <= bk_d;
            bad_acc_q <= bad_acc_d;
            occ_q     <= occ_d;
            kings_q   <= kings_d;
            badc_q    <= badc_d;
        end
    end

    assign sq_valid  = (state_q == StScan);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign sq_index  = idx_q;
    assign sq_piece  = piece_q;
    assign sq_cursor = cursor_q;
    assign sq_target = target_q;
    assign occ_count = occ_q;
    assign kings_ok  = kings_q;
    assign bad_code  = badc_q;

endmodule

// File: tb/tb_board_reader.sv
// Directed bench for board_reader: scan order, back-pressure, highlights, isolation, abort.
module tb_board_reader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] board = '0;
    logic [13:0]  moveData = '0;
    logic         start = 1'b0;
    logic         rd_ready = 1'b0;
    logic         sq_valid, sq_cursor, sq_target, busy, done, kings_ok, bad_code;
    logic [5:0]   sq_index;
    logic [3:0]   sq_piece;
    logic [6:0]   occ_count;

    int n_total = 0;
    int n_bad   = 0;

    int beat_idx [64];
    int beat_pc  [64];
    int beat_cur [64];
    int beat_tgt [64];
    int nacc, ndone, done_at, nacc_at_done;

`ifdef BOARD_READER_FLIP_EN
    localparam bit FlipEn = 1'b1;
`else
    localparam bit FlipEn = 1'b0;
`endif

    board_reader dut (
        .clk       (clk),
        .reset     (reset),
        .board     (board),
        .moveData  (moveData),
        .start     (start),
        .rd_ready  (rd_ready),
        .sq_valid  (sq_valid),
        .sq_index  (sq_index),
        .sq_piece  (sq_piece),
        .sq_cursor (sq_cursor),
        .sq_target (sq_target),
        .busy      (busy),
        .done      (done),
        .occ_count (occ_count),
        .kings_ok  (kings_ok),
        .bad_code  (bad_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] std_board();
        logic [255:0] b = '0;
        logic [3:0]   back [8];
        back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        for (int f = 0; f < 8; f++) begin
            b[(f)*4 +: 4]      = back[f];
            b[(8 + f)*4 +: 4]  = 4'd1;
            b[(48 + f)*4 +: 4] = 4'd9;
            b[(56 + f)*4 +: 4] = back[f] | 4'h8;
        end
        return b;
    endfunction

    // action: 0 none, 1 board change at beat 10 + start at beat 30, 2 reset at beat 20,
    // 3 start asserted during the done cycle
    task automatic run_scan(input int rdy_mode, input int action, input logic [13:0] mv);
        int         cyc;
        bit         stalled, aborted, did_start;
        logic [5:0] held_idx;
        logic [3:0] held_pc;
        nacc = 0; ndone = 0; done_at = -1; nacc_at_done = -1;
        stalled = 0; aborted = 0; did_start = 0;
        @(negedge clk);
        moveData = mv;
        start    = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 1000 && ndone == 0 && !aborted) begin
            start    = 1'b0;
            rd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            if (action == 1 && nacc == 10) board[3:0] = 4'd0;
            if (action == 1 && nacc == 30 && !did_start) begin
                start     = 1'b1;
                did_start = 1;
            end
            if (action == 2 && nacc == 20) begin
                reset = 1'b0;
                #1;
                check("abort_valid", sq_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_occ", occ_count, 0);
                check("abort_kings", kings_ok, 0);
                check("abort_bad", bad_code, 0);
                aborted = 1;
            end else begin
                if (sq_valid) begin
                    if (stalled) begin
                        check("stall_idx", sq_index, held_idx);
                        check("stall_pc", sq_piece, held_pc);
                    end
                    if (rd_ready) begin
                        if (nacc < 64) begin
                            beat_idx[nacc] = sq_index;
                            beat_pc[nacc]  = sq_piece;
                            beat_cur[nacc] = sq_cursor;
                            beat_tgt[nacc] = sq_target;
                        end
                        nacc++;
                        stalled = 0;
                    end else begin
                        stalled  = 1;
                        held_idx = sq_index;
                        held_pc  = sq_piece;
                    end
                end
                if (done) begin
                    ndone++;
                    done_at      = cyc;
                    nacc_at_done = nacc;
                    if (action == 3) start = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (cyc >= 1000) check("timeout", 1, 0);
        start = 1'b0;
        if (action == 3) check("b2b_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic verify(input string name, input logic [255:0] eb, input logic [13:0] mv,
                          input bit rev);
        int ti;
        check({name, "_nacc"}, nacc, 64);
        for (int k = 0; k < 64; k++) begin
            if (k < nacc) begin
                ti = rev ? 63 - k : k;
                check({name, "_idx"}, beat_idx[k], ti);
                check({name, "_pc"}, beat_pc[k], {28'd0, eb[ti*4 +: 4]});
                check({name, "_cur"}, beat_cur[k], {31'd0, ti[5:0] == mv[5:0]});
                check({name, "_tgt"}, beat_tgt[k], {31'd0, mv[12] && ti[5:0] == mv[11:6]});
            end
        end
    endtask

    initial begin
        logic [255:0] sb, eb;
        sb = std_board();
        board = sb;
        repeat (3) @(negedge clk);
        check("rst_valid", sq_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_occ", occ_count, 0);
        check("rst_kings", kings_ok, 0);
        check("rst_bad", bad_code, 0);
        reset = 1'b1;

        // Standard position, full rate
        run_scan(0, 0, 14'd0);
        verify("std", sb, 14'd0, 1'b0);
        check("std_beat0", beat_pc[0], 4);
        check("std_beat4", beat_pc[4], 6);
        check("std_beat60", beat_pc[60], 14);
        check("std_done_at", done_at, 65);
        check("std_ndone", ndone, 1);
        check("std_occ", occ_count, 32);
        check("std_kings", kings_ok, 1);
        check("std_bad", bad_code, 0);

        // Back-pressure
        run_scan(1, 0, 14'd0);
        verify("bp", sb, 14'd0, 1'b0);
        check("bp_acc_at_done", nacc_at_done, 64);
        check("bp_ndone", ndone, 1);

        // Cursor and target highlights; second run also tries start in the done cycle
        run_scan(0, 0, 14'b0_1_011100_001100);
        verify("hl", sb, 14'b0_1_011100_001100, 1'b0);
        run_scan(0, 3, 14'b0_0_011100_001100);
        verify("hl_nosel", sb, 14'b0_0_011100_001100, 1'b0);

        // Snapshot isolation
        run_scan(0, 1, 14'd0);
        verify("iso", sb, 14'd0, 1'b0);
        check("iso_beat0", beat_pc[0], 4);
        check("iso_ndone", ndone, 1);
        check("iso_occ", occ_count, 32);
        board = sb;

        // Error board: extra white king on d1, illegal code on f1
        eb = sb;
        eb[3*4 +: 4] = 4'd6;
        eb[5*4 +: 4] = 4'h7;
        board = eb;
        run_scan(0, 0, 14'd0);
        verify("err", eb, 14'd0, 1'b0);
        check("err_occ", occ_count, 32);
        check("err_kings", kings_ok, 0);
        check("err_bad", bad_code, 1);
        run_scan(0, 2, 14'd0);
        check("abort_ndone", ndone, 0);
        check("abort_occ_after", occ_count, 0);
        board = sb;

        // Black to move: reversed only when the flip feature is built in
        run_scan(0, 0, 14'b1_0_000000_000000);
        verify("flip", sb, 14'b1_0_000000_000000, FlipEn);
        check("flip_occ", occ_count, 32);
        check("flip_kings", kings_ok, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
